// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch prefetch queue.
// Issues in-order fetches to instruction memory, buffers up to DEPTH returned
// instructions with their PC+step, and hands them to decode over valid/ready.
// A branch redirect flushes the queue and marks every in-flight fetch as stale.
// An HLT opcode stops further fetching until the next redirect.
// Optional feature macro: PREFETCH_BYPASS_EN. When it is defined, a response that
// arrives at an empty queue is forwarded to the outputs in the same cycle.
module fetch_prefetch_queue #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HLT_OP   = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc_plus,
    input  logic               out_ready,
    output logic               halted
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StHalted
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   fetchPc_q, fetchPc_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       inflight_q, inflight_d;
    logic [CW-1:0]       drop_q, drop_d;

    logic [ADDR_W-1:0]   tagMem_q [DEPTH];
    logic [PW-1:0]       tagWr_q, tagRd_q;

    logic [INSTR_W-1:0]  instrMem_q [DEPTH];
    logic [ADDR_W-1:0]   pcMem_q [DEPTH];
    logic [PW-1:0]       head_q, tail_q;

    logic                reqFire;
    logic                dropPending;
    logic                respKeep;
    logic                isHlt;
    logic                pushEn;
    logic                popEn;
    logic [ADDR_W-1:0]   respPcPlus;

    // Requests stop once the queue entries plus the outstanding fetches fill the
    // queue, so a returning response always has a free slot.
    assign imem_req    = !rst && (state_q == StRun) && !redirect &&
                         (({1'b0, count_q} + {1'b0, inflight_q}) < CREDIT_LIMIT);
    assign imem_addr   = fetchPc_q;
    assign halted      = (state_q == StHalted);

    assign reqFire     = imem_req && imem_gnt;
    assign dropPending = (drop_q != '0);
    assign respKeep    = imem_rvalid && !dropPending && !redirect;
    assign isHlt       = (imem_rdata[INSTR_W-1 -: 4] == HLT_OP);
    assign respPcPlus  = tagMem_q[tagRd_q] + ADDR_W'(PC_STEP);
    assign popEn       = (count_q != '0) && out_ready;

`ifdef PREFETCH_BYPASS_EN
    logic bypassHit;

    assign bypassHit   = !rst && (count_q == '0) && respKeep;
    assign out_valid   = (count_q != '0) || bypassHit;
    assign out_instr   = bypassHit ? imem_rdata : instrMem_q[head_q];
    assign out_pc_plus = bypassHit ? respPcPlus : pcMem_q[head_q];
    assign pushEn      = respKeep && !(bypassHit && out_ready);
`else
    assign out_valid   = (count_q != '0);
    assign out_instr   = instrMem_q[head_q];
    assign out_pc_plus = pcMem_q[head_q];
    assign pushEn      = respKeep;
`endif

    // Next-state logic: counters, fetch PC and run/drain/halt state; redirect overrides.
    always_comb begin
        state_d    = state_q;
        fetchPc_d  = fetchPc_q;
        inflight_d = inflight_q + CW'(reqFire) - CW'(imem_rvalid);
        count_d    = count_q + CW'(pushEn) - CW'(popEn);
        drop_d     = drop_q;
        if (imem_rvalid && dropPending) begin
            drop_d = drop_q - CW'(1);
        end
        if (reqFire) begin
            fetchPc_d = fetchPc_q + ADDR_W'(PC_STEP);
        end
        case (state_q)
            StRun: begin
                if (respKeep && isHlt) begin
                    state_d = StHalted;
                end
            end
            StDrain: begin
                if (drop_d == '0) begin
                    state_d = StRun;
                end
            end
            default: begin
            end
        endcase
        if (redirect) begin
            count_d   = '0;
            drop_d    = inflight_d;
            fetchPc_d = redirect_pc;
            state_d   = (inflight_d != '0) ? StDrain : StRun;
        end
    end

    // State, counter and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            fetchPc_q  <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            tagWr_q    <= '0;
            tagRd_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetchPc_q  <= fetchPc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            if (redirect) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                if (popEn) begin
                    head_q <= head_q + PW'(1);
                end
                if (pushEn) begin
                    tail_q <= tail_q + PW'(1);
                end
            end
            if (reqFire) begin
                tagWr_q <= tagWr_q + PW'(1);
            end
            if (imem_rvalid) begin
                tagRd_q <= tagRd_q + PW'(1);
            end
        end
    end

    // Storage: the request-address tag FIFO and the instruction/PC queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tagMem_q[i]   <= '0;
                instrMem_q[i] <= '0;
                pcMem_q[i]    <= '0;
            end
        end else begin
            if (reqFire) begin
                tagMem_q[tagWr_q] <= fetchPc_q;
            end
            if (pushEn) begin
                instrMem_q[tail_q] <= imem_rdata;
                pcMem_q[tail_q]    <= respPcPlus;
            end
        end
    end

endmodule
